// File: rtl/alu_exec_unit.sv
// ALU control decode plus execute stage. Single-cycle ops complete in one clock;
// MUL runs an iterative shift-add over WIDTH clocks. valid/ready on both sides.
module alu_exec_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [9:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic [3:0]       out_func,
    output logic             out_illegal,
    output logic             busy
);

    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        F_AND = 4'b0000,
        F_OR  = 4'b0001,
        F_ADD = 4'b0010,
        F_XOR = 4'b0011,
        F_SLL = 4'b0100,
        F_SRL = 4'b0101,
        F_SUB = 4'b0110,
        F_SRA = 4'b0111,
        F_SLT = 4'b1000,
        F_MUL = 4'b1001,
        F_ILL = 4'b1111
    } func_t;

    state_t            state_q, state_d;
    func_t             func_q, func_d;
    logic              illegal_q, illegal_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [SW-1:0]     count_q, count_d;

    func_t             dec_func;
    logic [WIDTH-1:0]  exec_res;
    logic [SW-1:0]     shamt;
    logic [WIDTH-1:0]  acc_step;
    logic              accept;

    always_comb begin
        dec_func = F_ILL;
        unique case (alu_op)
            2'b00: dec_func = F_ADD;
            2'b01: dec_func = F_SUB;
            2'b10: begin
                unique case (funct)
                    10'b0000000_000: dec_func = F_ADD;
                    10'b0100000_000: dec_func = F_SUB;
                    10'b0000000_111: dec_func = F_AND;
                    10'b0000000_110: dec_func = F_OR;
                    10'b0000000_100: dec_func = F_XOR;
                    10'b0000000_001: dec_func = F_SLL;
                    10'b0000000_101: dec_func = F_SRL;
                    10'b0100000_101: dec_func = F_SRA;
                    10'b0000000_010: dec_func = F_SLT;
                    10'b0000001_000: begin
                        if (MUL_EN) dec_func = F_MUL;
                        else        dec_func = F_ILL;
                    end
                    default:         dec_func = F_ILL;
                endcase
            end
            default: dec_func = F_ILL;
        endcase
    end

    assign shamt = op_b[SW-1:0];

    always_comb begin
        exec_res = '0;
        unique case (dec_func)
            F_ADD: exec_res = op_a + op_b;
            F_SUB: exec_res = op_a - op_b;
            F_AND: exec_res = op_a & op_b;
            F_OR:  exec_res = op_a | op_b;
            F_XOR: exec_res = op_a ^ op_b;
            F_SLL: exec_res = op_a << shamt;
            F_SRL: exec_res = op_a >> shamt;
            F_SRA: exec_res = WIDTH'($unsigned($signed(op_a) >>> shamt));
            F_SLT: exec_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: exec_res = '0;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        illegal_d = illegal_q;
        result_d  = result_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;

        unique case (state_q)
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + SW'(1);
                if (count_q == SW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_step;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        // A new accept overrides the DONE->IDLE drain so consecutive ops see no bubble.
        if (accept) begin
            func_d    = dec_func;
            illegal_d = (dec_func == F_ILL);
            if (dec_func == F_MUL) begin
                state_d  = S_MUL;
                mcand_d  = op_a;
                mplier_d = op_b;
                acc_d    = '0;
                count_d  = '0;
            end else begin
                state_d  = S_DONE;
                result_d = exec_res;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            func_q    <= F_AND;
            illegal_q <= 1'b0;
            result_q  <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            illegal_q <= illegal_d;
            result_q  <= result_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
        end
    end

    // Outputs are gated by DONE so stale registers never leak while idle or iterating.
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = out_valid ? result_q : '0;
    assign out_func    = out_valid ? func_q : 4'b0000;
    assign out_illegal = out_valid & illegal_q;
    assign out_zero    = out_valid & (result_q == '0);
    assign busy        = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one DUT with MUL, one built without MUL.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  alu_op;
    logic [9:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        in_ready,  out_valid,  out_zero,  out_illegal,  busy;
    logic [31:0] out_result;
    logic [3:0]  out_func;
    logic        in_ready0, out_valid0, out_zero0, out_illegal0, busy0;
    logic [31:0] out_result0;
    logic [3:0]  out_func0;

    int vecs = 0;
    int errs = 0;

    localparam logic [9:0] FN_MUL = 10'b0000001_000;

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_func(out_func),
        .out_illegal(out_illegal), .busy(busy)
    );

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_result(out_result0), .out_zero(out_zero0), .out_func(out_func0),
        .out_illegal(out_illegal0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [9:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        funct    = f;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if ({out_valid, busy, in_ready, out_result} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            errs++;
            $display("FAIL reset_initial got=%h exp=%h", {out_valid, busy, in_ready, out_result},
                     {1'b0, 1'b0, 1'b1, 32'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        drive(2'b10, FN_MUL, 32'd3, 32'd7);
        tick;
        in_valid = 1'b0;
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL reset_mul_started busy got=%b exp=1", busy);
        end
        tick;
        tick;
        #3;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({out_valid, busy, in_ready, out_result, out_func} !== {3'b001, 32'h0, 4'h0}) begin
            errs++;
            $display("FAIL reset_async got=%h exp=%h", {out_valid, busy, in_ready, out_result, out_func},
                     {3'b001, 32'h0, 4'h0});
        end
        vecs++;
        if ({out_valid0, busy0, in_ready0} !== 3'b001) begin
            errs++;
            $display("FAIL reset_async_nomul got=%b exp=001", {out_valid0, busy0, in_ready0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_rtype;
        logic [9:0]  f  [10];
        logic [31:0] a  [10];
        logic [31:0] b  [10];
        logic [31:0] r  [10];
        logic [3:0]  fn [10];
        f[0] = 10'b0000000_111; a[0] = 32'hF0F0_0000; b[0] = 32'hFFFF_0000; r[0] = 32'hF0F0_0000; fn[0] = 4'b0000;
        f[1] = 10'b0100000_101; a[1] = 32'h8000_0000; b[1] = 32'h0000_0004; r[1] = 32'hF800_0000; fn[1] = 4'b0111;
        f[2] = 10'b0000000_010; a[2] = 32'hFFFF_FFFF; b[2] = 32'h0000_0001; r[2] = 32'h0000_0001; fn[2] = 4'b1000;
        f[3] = 10'b0000000_010; a[3] = 32'h0000_0001; b[3] = 32'hFFFF_FFFF; r[3] = 32'h0000_0000; fn[3] = 4'b1000;
        f[4] = 10'b0000000_110; a[4] = 32'h0F00_00F0; b[4] = 32'h0000_0F0F; r[4] = 32'h0F00_0FFF; fn[4] = 4'b0001;
        f[5] = 10'b0000000_100; a[5] = 32'hFFFF_0000; b[5] = 32'h0F0F_0F0F; r[5] = 32'hF0F0_0F0F; fn[5] = 4'b0011;
        f[6] = 10'b0000000_001; a[6] = 32'h0000_0001; b[6] = 32'h0000_003F; r[6] = 32'h8000_0000; fn[6] = 4'b0100;
        f[7] = 10'b0000000_101; a[7] = 32'h8000_0000; b[7] = 32'h0000_0004; r[7] = 32'h0800_0000; fn[7] = 4'b0101;
        f[8] = 10'b0100000_000; a[8] = 32'd10;        b[8] = 32'd3;        r[8] = 32'd7;         fn[8] = 4'b0110;
        f[9] = 10'b0000001_001; a[9] = 32'h1234_5678; b[9] = 32'h0000_0001; r[9] = 32'h0;       fn[9] = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(2'b10, f[i], a[i], b[i]);
            tick;
            vecs++;
            if ({out_valid, out_func, out_illegal, out_zero, out_result} !==
                {1'b1, fn[i], (fn[i] == 4'hF), (r[i] == 32'h0), r[i]}) begin
                errs++;
                $display("FAIL rtype[%0d] got=%h exp=%h", i,
                         {out_valid, out_func, out_illegal, out_zero, out_result},
                         {1'b1, fn[i], (fn[i] == 4'hF), (r[i] == 32'h0), r[i]});
            end
            in_valid = 1'b0;
            tick;
            vecs++;
            if (out_valid !== 1'b0) begin
                errs++;
                $display("FAIL rtype_drain[%0d] out_valid got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_wrap_zero;
        logic [1:0]  op [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        logic [31:0] r  [4];
        logic [3:0]  fn [4];
        op[0] = 2'b00; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1; r[0] = 32'h0;         fn[0] = 4'b0010;
        op[1] = 2'b01; a[1] = 32'd5;         b[1] = 32'd5; r[1] = 32'h0;         fn[1] = 4'b0110;
        op[2] = 2'b00; a[2] = 32'd3;         b[2] = 32'd4; r[2] = 32'd7;         fn[2] = 4'b0010;
        op[3] = 2'b01; a[3] = 32'd0;         b[3] = 32'd1; r[3] = 32'hFFFF_FFFF; fn[3] = 4'b0110;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(op[i], 10'b0100000_111, a[i], b[i]);
            tick;
            vecs++;
            if ({out_valid, out_func, out_illegal, out_zero, out_result} !==
                {1'b1, fn[i], 1'b0, (r[i] == 32'h0), r[i]}) begin
                errs++;
                $display("FAIL wrap[%0d] got=%h exp=%h", i,
                         {out_valid, out_func, out_illegal, out_zero, out_result},
                         {1'b1, fn[i], 1'b0, (r[i] == 32'h0), r[i]});
            end
            in_valid = 1'b0;
            tick;
        end
    endtask

    task automatic test_mul;
        out_ready = 1'b1;
        drive(2'b10, FN_MUL, 32'd12345, 32'd678);
        tick;
        vecs++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            errs++;
            $display("FAIL mul_step0 got=%b exp=100", {busy, in_ready, out_valid});
        end
        vecs++;
        if ({out_valid0, out_illegal0, out_func0, out_zero0, out_result0} !== {3'b111, 4'hF, 32'h0}) begin
            errs++;
            $display("FAIL mul_disabled got=%h exp=%h", {out_valid0, out_illegal0, out_func0, out_zero0, out_result0},
                     {3'b111, 4'hF, 32'h0});
        end
        drive(2'b00, 10'h0, 32'hDEAD_BEEF, 32'h1111_1111);
        for (int k = 1; k < 32; k++) begin
            tick;
            vecs++;
            if ({busy, in_ready, out_valid} !== 3'b100) begin
                errs++;
                $display("FAIL mul_step%0d got=%b exp=100", k, {busy, in_ready, out_valid});
            end
            if (k == 31) in_valid = 1'b0;
        end
        tick;
        vecs++;
        if ({out_valid, busy, out_func, out_illegal, out_zero, out_result} !==
            {2'b10, 4'b1001, 2'b00, 32'h007F_B6F6}) begin
            errs++;
            $display("FAIL mul_result got=%h exp=%h", {out_valid, busy, out_func, out_illegal, out_zero, out_result},
                     {2'b10, 4'b1001, 2'b00, 32'h007F_B6F6});
        end
        tick;
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mul_drain out_valid got=%b exp=0", out_valid);
        end
        drive(2'b10, FN_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick;
        in_valid = 1'b0;
        repeat (31) tick;
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL mul2_early out_valid got=%b exp=0", out_valid);
        end
        tick;
        vecs++;
        if ({out_valid, out_result} !== {1'b1, 32'h0000_0001}) begin
            errs++;
            $display("FAIL mul2_result got=%h exp=%h", {out_valid, out_result}, {1'b1, 32'h0000_0001});
        end
        tick;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(2'b10, 10'b0000000_100, 32'hAAAA_5555, 32'h0000_FFFF);
        tick;
        drive(2'b01, 10'h0, 32'd100, 32'd1);
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if ({out_valid, in_ready, out_func, out_result} !== {2'b10, 4'b0011, 32'hAAAA_AAAA}) begin
                errs++;
                $display("FAIL hold[%0d] got=%h exp=%h", k, {out_valid, in_ready, out_func, out_result},
                         {2'b10, 4'b0011, 32'hAAAA_AAAA});
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL release_in_ready got=%b exp=1", in_ready);
        end
        tick;
        vecs++;
        if ({out_valid, out_func, out_result} !== {1'b1, 4'b0110, 32'd99}) begin
            errs++;
            $display("FAIL release_next got=%h exp=%h", {out_valid, out_func, out_result}, {1'b1, 4'b0110, 32'd99});
        end
        in_valid = 1'b0;
        tick;
        vecs++;
        if ({out_valid, out_zero, out_result} !== {2'b00, 32'h0}) begin
            errs++;
            $display("FAIL release_idle got=%h exp=%h", {out_valid, out_zero, out_result}, {2'b00, 32'h0});
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        drive(2'b00, 10'h0, 32'd1, 32'd2);
        tick;
        vecs++;
        if ({out_valid, out_func, out_result} !== {1'b1, 4'b0010, 32'd3}) begin
            errs++;
            $display("FAIL b2b_0 got=%h exp=%h", {out_valid, out_func, out_result}, {1'b1, 4'b0010, 32'd3});
        end
        drive(2'b01, 10'h0, 32'd10, 32'd4);
        tick;
        vecs++;
        if ({out_valid, out_func, out_result} !== {1'b1, 4'b0110, 32'd6}) begin
            errs++;
            $display("FAIL b2b_1 got=%h exp=%h", {out_valid, out_func, out_result}, {1'b1, 4'b0110, 32'd6});
        end
        drive(2'b10, 10'b0000000_111, 32'h0000_FF0F, 32'h0000_0FF0);
        tick;
        vecs++;
        if ({out_valid, out_func, out_result} !== {1'b1, 4'b0000, 32'h0000_0F00}) begin
            errs++;
            $display("FAIL b2b_2 got=%h exp=%h", {out_valid, out_func, out_result}, {1'b1, 4'b0000, 32'h0000_0F00});
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_illegal_flush;
        logic seen;
        out_ready = 1'b1;
        drive(2'b11, 10'h000, 32'd5, 32'd6);
        tick;
        vecs++;
        if ({out_valid, out_func, out_illegal, out_zero, out_result} !== {1'b1, 4'hF, 2'b11, 32'h0}) begin
            errs++;
            $display("FAIL illegal_op got=%h exp=%h", {out_valid, out_func, out_illegal, out_zero, out_result},
                     {1'b1, 4'hF, 2'b11, 32'h0});
        end
        in_valid = 1'b0;
        tick;
        drive(2'b10, FN_MUL, 32'd7, 32'd9);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        vecs++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errs++;
            $display("FAIL flush_mul got=%b exp=001", {out_valid, busy, in_ready});
        end
        seen = 1'b0;
        repeat (40) begin
            tick;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL flush_no_result seen=%b exp=0", seen);
        end
        flush = 1'b1;
        drive(2'b00, 10'h0, 32'd1, 32'd1);
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        vecs++;
        if ({out_valid, busy} !== 2'b00) begin
            errs++;
            $display("FAIL flush_over_accept got=%b exp=00", {out_valid, busy});
        end
        drive(2'b10, FN_MUL, 32'd3, 32'd5);
        tick;
        in_valid = 1'b0;
        repeat (31) tick;
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++;
            $display("FAIL post_flush_mul_early out_valid got=%b exp=0", out_valid);
        end
        tick;
        vecs++;
        if ({out_valid, out_result} !== {1'b1, 32'd15}) begin
            errs++;
            $display("FAIL post_flush_mul got=%h exp=%h", {out_valid, out_result}, {1'b1, 32'd15});
        end
        tick;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct     = 10'h0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        test_reset;
        test_rtype;
        test_wrap_zero;
        test_mul;
        test_backpressure;
        test_back_to_back;
        test_illegal_flush;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
